// File: rtl/snake_input_ctrl_if.sv
// Bundle of raw button inputs, the game-step strobe, and the committed direction/pause outputs
// exchanged between the snake input controller and its environment.
interface snake_input_ctrl_if;
   logic       btn_up;
   logic       btn_down;
   logic       btn_left;
   logic       btn_right;
   logic       btn_pause;
   logic       tick;
   logic [3:0] moveState;
   logic       isPaused;
   logic       dir_changed;

   modport master (
      output btn_up, btn_down, btn_left, btn_right, btn_pause, tick,
      input  moveState, isPaused, dir_changed
   );

   modport slave (
      input  btn_up, btn_down, btn_left, btn_right, btn_pause, tick,
      output moveState, isPaused, dir_changed
   );
endinterface

// File: rtl/snake_input_ctrl.sv
// Snake game input controller: synchronizes and debounces five push-buttons, then turns accepted
// presses into a pending direction that is committed on each game tick, plus a pause toggle.
module snake_input_ctrl #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int CNT_W           = 18
) (
   input  logic               clk,
   input  logic               rst_n,
   snake_input_ctrl_if.slave  ctrl_if
);

   localparam int NBTN    = 5;
   localparam int B_UP    = 0;
   localparam int B_DOWN  = 1;
   localparam int B_LEFT  = 2;
   localparam int B_PAUSE = 4;

   localparam logic [1:0] DIR_UP    = 2'd0;
   localparam logic [1:0] DIR_DOWN  = 2'd1;
   localparam logic [1:0] DIR_LEFT  = 2'd2;
   localparam logic [1:0] DIR_RIGHT = 2'd3;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [NBTN-1:0]  btn_raw;
   logic [NBTN-1:0]  sync1_q, sync2_q;
   logic [NBTN-1:0]  level_q, level_d;
   logic [NBTN-1:0]  press_q, press_d;
   logic [CNT_W-1:0] cnt_q [NBTN];
   logic [CNT_W-1:0] cnt_d [NBTN];

   logic [1:0] move_q, move_d;
   logic [1:0] pend_q, pend_d;
   logic       paused_q, paused_d;
   logic       dchg_q, dchg_d;

   logic       dir_ev;
   logic [1:0] dir_req;
   logic       dir_ok;
   logic       pause_ev;

   assign btn_raw = {ctrl_if.btn_pause, ctrl_if.btn_right, ctrl_if.btn_left,
                     ctrl_if.btn_down, ctrl_if.btn_up};

   // The level flips on the cycle the mismatch run would reach DEBOUNCE_CYCLES; only rising flips raise a press
   always_comb begin
      for (int b = 0; b < NBTN; b++) begin
         level_d[b] = level_q[b];
         press_d[b] = 1'b0;
         cnt_d[b]   = '0;
         if (sync2_q[b] != level_q[b]) begin
            if (cnt_q[b] == CNT_LAST) begin
               level_d[b] = sync2_q[b];
               press_d[b] = sync2_q[b];
            end else begin
               cnt_d[b] = cnt_q[b] + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
         level_q <= '0;
         press_q <= '0;
         for (int b = 0; b < NBTN; b++) cnt_q[b] <= '0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
         level_q <= level_d;
         press_q <= press_d;
         for (int b = 0; b < NBTN; b++) cnt_q[b] <= cnt_d[b];
      end
   end

   always_comb begin
      dir_ev  = |press_q[3:0];
      dir_req = DIR_RIGHT;
      if (press_q[B_UP])        dir_req = DIR_UP;
      else if (press_q[B_DOWN]) dir_req = DIR_DOWN;
      else if (press_q[B_LEFT]) dir_req = DIR_LEFT;
      pause_ev = press_q[B_PAUSE];
      // Opposite directions differ only in bit 0 (up/down, left/right)
      dir_ok = dir_ev && !paused_q && (dir_req != move_q) && (dir_req != (move_q ^ 2'b01));
   end

   always_comb begin
      move_d   = move_q;
      dchg_d   = 1'b0;
      pend_d   = pend_q;
      paused_d = paused_q;
      if (ctrl_if.tick && !paused_q) begin
         move_d = pend_q;
         dchg_d = (pend_q != move_q);
      end
      // Entering pause drops any unsent turn, aligned to whatever this edge commits
      if (pause_ev) begin
         paused_d = !paused_q;
         if (!paused_q) pend_d = move_d;
      end else if (dir_ok) begin
         pend_d = dir_req;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         move_q   <= DIR_RIGHT;
         pend_q   <= DIR_RIGHT;
         paused_q <= 1'b0;
         dchg_q   <= 1'b0;
      end else begin
         move_q   <= move_d;
         pend_q   <= pend_d;
         paused_q <= paused_d;
         dchg_q   <= dchg_d;
      end
   end

   assign ctrl_if.moveState   = {2'b00, move_q};
   assign ctrl_if.isPaused    = paused_q;
   assign ctrl_if.dir_changed = dchg_q;

endmodule

// File: tb/tb_snake_input_ctrl.sv
// Bench for snake_input_ctrl with a short debounce window: directed scenarios with fixed expectations
// followed by random button/tick traffic compared against a history-based behavioural model.
module tb_snake_input_ctrl;

   localparam int D = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   snake_input_ctrl_if bus ();

   snake_input_ctrl #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .ctrl_if(bus)
   );

   always #5 clk = ~clk;

   // Model: raw samples per edge, accepted levels, pending events, game state
   logic [4:0] m_hist[$];
   logic [4:0] m_lvl, m_ev;
   int         m_move, m_pend;
   bit         m_paused, m_dchg;

   function automatic int opposite(input int d);
      case (d)
         0: return 1;
         1: return 0;
         2: return 3;
         default: return 2;
      endcase
   endfunction

   task automatic model_reset();
      m_hist.delete();
      repeat (D + 2) m_hist.push_back(5'b0);
      m_lvl = '0; m_ev = '0;
      m_move = 3; m_pend = 3; m_paused = 0; m_dchg = 0;
   endtask

   // Effect of the coming rising edge given the inputs currently applied
   task automatic model_step();
      logic [4:0] raw;
      int new_move, req;
      bit have, dchg, all_diff;
      raw = {bus.btn_pause, bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};
      new_move = m_move; dchg = 0;
      if (bus.tick && !m_paused) begin
         new_move = m_pend;
         dchg = (m_pend != m_move);
      end
      have = 0; req = 0;
      for (int b = 0; b < 4; b++) if (m_ev[b] && !have) begin have = 1; req = b; end
      if (m_ev[4]) begin
         if (!m_paused) m_pend = new_move;
         m_paused = !m_paused;
      end else if (have && !m_paused && req != m_move && req != opposite(m_move)) begin
         m_pend = req;
      end
      m_move = new_move; m_dchg = dchg;
      // A level is accepted once D consecutive samples, seen two edges late, all disagree with it
      m_hist.push_back(raw);
      if (m_hist.size() > D + 2) void'(m_hist.pop_front());
      m_ev = '0;
      for (int b = 0; b < 5; b++) begin
         all_diff = 1;
         for (int i = 0; i < D; i++) if (m_hist[i][b] == m_lvl[b]) all_diff = 0;
         if (all_diff) begin
            m_lvl[b] = ~m_lvl[b];
            if (m_lvl[b]) m_ev[b] = 1'b1;
         end
      end
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.btn_up = 0; bus.btn_down = 0; bus.btn_left = 0; bus.btn_right = 0;
      bus.btn_pause = 0; bus.tick = 0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      clear_inputs();
      repeat (3) step();
      rst_n = 1'b0;
      #2;
      n_checks++; if (bus.moveState !== 4'd3) begin n_fail++; $display("FAIL reset_move: got %0d expected 3", bus.moveState); end
      n_checks++; if (bus.isPaused !== 1'b0) begin n_fail++; $display("FAIL reset_pause: got %b expected 0", bus.isPaused); end
      n_checks++; if (bus.dir_changed !== 1'b0) begin n_fail++; $display("FAIL reset_dchg: got %b expected 0", bus.dir_changed); end
      do_reset();
   endtask

   // btn_up held through reset release: event consumed on edge 7, so only the tick on edge 8 turns
   task automatic test_hold_up();
      clear_inputs();
      bus.btn_up = 1;
      do_reset();
      bus.tick = 1;
      for (int e = 1; e <= 8; e++) begin
         step();
         n_checks++; if (bus.moveState !== ((e >= 8) ? 4'd0 : 4'd3)) begin n_fail++; $display("FAIL hold_up_move edge %0d: got %0d expected %0d", e, bus.moveState, (e >= 8) ? 0 : 3); end
         n_checks++; if (bus.dir_changed !== (e == 8)) begin n_fail++; $display("FAIL hold_up_dchg edge %0d: got %b expected %b", e, bus.dir_changed, e == 8); end
      end
      bus.tick = 0;
      step();
      n_checks++; if (bus.dir_changed !== 1'b0 || bus.moveState !== 4'd0) begin n_fail++; $display("FAIL hold_up_after: got move %0d dchg %b expected 0/0", bus.moveState, bus.dir_changed); end
      bus.btn_up = 0;
      repeat (8) step();
   endtask

   task automatic test_reversal();
      clear_inputs();
      do_reset();
      bus.btn_left = 1; repeat (8) step(); bus.btn_left = 0; repeat (8) step();
      bus.tick = 1; step(); bus.tick = 0;
      n_checks++; if (bus.moveState !== 4'd3 || bus.dir_changed !== 1'b0) begin n_fail++; $display("FAIL reversal_blocked: got move %0d dchg %b expected 3/0", bus.moveState, bus.dir_changed); end
      bus.btn_down = 1; repeat (8) step(); bus.btn_down = 0; repeat (8) step();
      bus.tick = 1; step(); bus.tick = 0;
      n_checks++; if (bus.moveState !== 4'd1 || bus.dir_changed !== 1'b1) begin n_fail++; $display("FAIL turn_down: got move %0d dchg %b expected 1/1", bus.moveState, bus.dir_changed); end
   endtask

   task automatic test_glitch();
      clear_inputs();
      do_reset();
      bus.btn_up = 1; repeat (3) step(); bus.btn_up = 0;
      for (int c = 0; c < 12; c++) begin
         bus.tick = (c % 4 == 3);
         step();
         n_checks++; if (bus.moveState !== 4'd3 || bus.dir_changed !== 1'b0) begin n_fail++; $display("FAIL glitch_cycle %0d: got move %0d dchg %b expected 3/0", c, bus.moveState, bus.dir_changed); end
      end
      bus.tick = 0;
      bus.btn_up = 1; repeat (4) step(); bus.btn_up = 0; repeat (8) step();
      bus.tick = 1; step(); bus.tick = 0;
      n_checks++; if (bus.moveState !== 4'd0 || bus.dir_changed !== 1'b1) begin n_fail++; $display("FAIL min_pulse: got move %0d dchg %b expected 0/1", bus.moveState, bus.dir_changed); end
   endtask

   task automatic test_priority();
      clear_inputs();
      do_reset();
      bus.btn_up = 1; bus.btn_left = 1; repeat (8) step();
      bus.btn_up = 0; bus.btn_left = 0; repeat (8) step();
      bus.tick = 1; step(); bus.tick = 0;
      n_checks++; if (bus.moveState !== 4'd0 || bus.dir_changed !== 1'b1) begin n_fail++; $display("FAIL prio_up_left: got move %0d dchg %b expected 0/1", bus.moveState, bus.dir_changed); end
      // down wins over right, is then rejected as a reversal, and right is discarded
      bus.btn_down = 1; bus.btn_right = 1; repeat (8) step();
      bus.btn_down = 0; bus.btn_right = 0; repeat (8) step();
      bus.tick = 1; step(); bus.tick = 0;
      n_checks++; if (bus.moveState !== 4'd0 || bus.dir_changed !== 1'b0) begin n_fail++; $display("FAIL prio_discard: got move %0d dchg %b expected 0/0", bus.moveState, bus.dir_changed); end
   endtask

   task automatic test_pause();
      clear_inputs();
      do_reset();
      bus.btn_pause = 1; repeat (30) step(); bus.btn_pause = 0; repeat (8) step();
      n_checks++; if (bus.isPaused !== 1'b1) begin n_fail++; $display("FAIL pause_held_once: got %b expected 1", bus.isPaused); end
      bus.btn_down = 1; repeat (8) step(); bus.btn_down = 0; repeat (8) step();
      bus.tick = 1;
      for (int t = 0; t < 5; t++) begin
         step();
         n_checks++; if (bus.moveState !== 4'd3 || bus.dir_changed !== 1'b0) begin n_fail++; $display("FAIL paused_tick %0d: got move %0d dchg %b expected 3/0", t, bus.moveState, bus.dir_changed); end
      end
      bus.tick = 0;
      bus.btn_pause = 1; repeat (8) step(); bus.btn_pause = 0; repeat (8) step();
      n_checks++; if (bus.isPaused !== 1'b0) begin n_fail++; $display("FAIL unpause: got %b expected 0", bus.isPaused); end
      bus.tick = 1; step(); bus.tick = 0;
      n_checks++; if (bus.moveState !== 4'd3 || bus.dir_changed !== 1'b0) begin n_fail++; $display("FAIL unpause_tick: got move %0d dchg %b expected 3/0", bus.moveState, bus.dir_changed); end
      bus.btn_up = 1; repeat (8) step(); bus.btn_up = 0; repeat (8) step();
      bus.tick = 1; step(); bus.tick = 0;
      n_checks++; if (bus.moveState !== 4'd0 || bus.dir_changed !== 1'b1) begin n_fail++; $display("FAIL resume_turn: got move %0d dchg %b expected 0/1", bus.moveState, bus.dir_changed); end
   endtask

   task automatic test_pause_tick();
      clear_inputs();
      do_reset();
      bus.btn_down = 1; repeat (8) step(); bus.btn_down = 0; repeat (8) step();
      bus.btn_pause = 1; repeat (6) step();
      n_checks++; if (bus.isPaused !== 1'b0) begin n_fail++; $display("FAIL pause_latency: got %b expected 0", bus.isPaused); end
      bus.tick = 1; step(); bus.tick = 0;
      n_checks++; if (bus.moveState !== 4'd1 || bus.dir_changed !== 1'b1 || bus.isPaused !== 1'b1) begin n_fail++; $display("FAIL pause_with_tick: got move %0d dchg %b paused %b expected 1/1/1", bus.moveState, bus.dir_changed, bus.isPaused); end
      bus.btn_pause = 0; repeat (8) step();
      bus.tick = 1; step(); bus.tick = 0;
      n_checks++; if (bus.moveState !== 4'd1 || bus.dir_changed !== 1'b0) begin n_fail++; $display("FAIL paused_hold: got move %0d dchg %b expected 1/0", bus.moveState, bus.dir_changed); end
   endtask

   task automatic test_random();
      clear_inputs();
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 7) == 0) bus.btn_up    = ~bus.btn_up;
         if ($urandom_range(0, 7) == 0) bus.btn_down  = ~bus.btn_down;
         if ($urandom_range(0, 7) == 0) bus.btn_left  = ~bus.btn_left;
         if ($urandom_range(0, 7) == 0) bus.btn_right = ~bus.btn_right;
         if ($urandom_range(0, 9) == 0) bus.btn_pause = ~bus.btn_pause;
         bus.tick = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 499) == 0) begin
            rst_n = 1'b0;
            model_reset();
            #2;
            n_checks++; if (bus.moveState !== 4'd3 || bus.isPaused !== 1'b0) begin n_fail++; $display("FAIL rand_reset %0d: got move %0d paused %b expected 3/0", c, bus.moveState, bus.isPaused); end
            rst_n = 1'b1;
         end
         step();
         n_checks++;
         if (bus.moveState !== 4'(m_move) || bus.isPaused !== m_paused || bus.dir_changed !== m_dchg) begin
            n_fail++;
            $display("FAIL rand_cycle %0d: got move %0d paused %b dchg %b expected %0d/%b/%b", c, bus.moveState, bus.isPaused, bus.dir_changed, m_move, m_paused, m_dchg);
         end
      end
   endtask

   initial begin
      clear_inputs();
      model_reset();
      test_reset();
      test_hold_up();
      test_reversal();
      test_glitch();
      test_priority();
      test_pause();
      test_pause_tick();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
